// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: ID-stage RAW/WAW hazard scoreboard with operand forwarding.
// Ports: clk_i/reset_i (async active-high); issue_valid_i/es_allowin_i -> issue_ready_o;
// src{1,2}_addr_i/_used_i/_rf_data_i -> src{1,2}_value_o; issue_we_i/issue_dest_i;
// fwd_valid_i/fwd_data_ok_i/fwd_dest_i/fwd_data_i (channel 0 youngest);
// wb_valid_i/wb_we_i/wb_dest_i/wb_data_i retire port; flush_i; stall_cnt_o; err_underflow_o.
module id_hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int NFWD  = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             issue_valid_i,
  input  logic             es_allowin_i,
  output logic             issue_ready_o,
  input  logic [AW-1:0]    src1_addr_i,
  input  logic [AW-1:0]    src2_addr_i,
  input  logic             src1_used_i,
  input  logic             src2_used_i,
  input  logic [DW-1:0]    src1_rf_data_i,
  input  logic [DW-1:0]    src2_rf_data_i,
  input  logic             issue_we_i,
  input  logic [AW-1:0]    issue_dest_i,
  input  logic [NFWD-1:0]  fwd_valid_i,
  input  logic [NFWD-1:0]  fwd_data_ok_i,
  input  logic [NFWD*AW-1:0] fwd_dest_i,
  input  logic [NFWD*DW-1:0] fwd_data_i,
  input  logic             wb_valid_i,
  input  logic             wb_we_i,
  input  logic [AW-1:0]    wb_dest_i,
  input  logic [DW-1:0]    wb_data_i,
  input  logic             flush_i,
  output logic [DW-1:0]    src1_value_o,
  output logic [DW-1:0]    src2_value_o,
  output logic [31:0]      stall_cnt_o,
  output logic             err_underflow_o
);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [31:0]      stall_q, stall_d;
  logic             err_q, err_d;
  logic [AW-1:0]    sa  [2];
  logic             su  [2];
  logic [DW-1:0]    srf [2];
  logic [DW-1:0]    sv  [2];
  logic             sh  [2];
  logic             hit [2];
  logic             wbm [2];
  logic             wb_ret, waw_full, issue_fire, inc, dec;
  assign wb_ret = wb_valid_i & wb_we_i;
  // Operand resolution: youngest matching forward channel wins, then the
  // retiring writeback, then the regfile. A pending producer that is not
  // visible on any path makes the source a hazard.
  always_comb begin
    sa[0] = src1_addr_i;
    sa[1] = src2_addr_i;
    su[0] = src1_used_i;
    su[1] = src2_used_i;
    srf[0] = src1_rf_data_i;
    srf[1] = src2_rf_data_i;
    for (int s = 0; s < 2; s++) begin
      hit[s] = 1'b0;
      sv[s] = srf[s];
      sh[s] = 1'b0;
      for (int i = NFWD - 1; i >= 0; i--)
        if (fwd_valid_i[i] && fwd_dest_i[i*AW +: AW] == sa[s]) begin
          hit[s] = 1'b1;
          sv[s] = fwd_data_i[i*DW +: DW];
          sh[s] = ~fwd_data_ok_i[i];
        end
      wbm[s] = wb_ret & (wb_dest_i == sa[s]);
      if (!hit[s]) begin
        sv[s] = wbm[s] ? wb_data_i : srf[s];
        sh[s] = (cnt_q[sa[s]] > CNT_W'(1)) | ((cnt_q[sa[s]] == CNT_W'(1)) & ~wbm[s]);
      end
      if (sa[s] == '0) begin
        sv[s] = '0;
        sh[s] = 1'b0;
      end
      if (!su[s]) sh[s] = 1'b0;
    end
  end
  assign src1_value_o = sv[0];
  assign src2_value_o = sv[1];
  // A saturated writer counter may still accept one more writer when the
  // same register retires this cycle, since the net count does not change.
  assign waw_full = issue_we_i & (issue_dest_i != '0) & (cnt_q[issue_dest_i] == MAX)
                  & ~(wb_ret & (wb_dest_i == issue_dest_i));
  assign issue_ready_o = es_allowin_i & ~sh[0] & ~sh[1] & ~waw_full & ~flush_i;
  assign issue_fire = issue_valid_i & issue_ready_o;
  always_comb begin
    err_d = err_q;
    inc = 1'b0;
    dec = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      inc = issue_fire & issue_we_i & (issue_dest_i == AW'(r)) & (r != 0);
      dec = wb_ret & (wb_dest_i == AW'(r)) & (r != 0);
      cnt_d[r] = flush_i ? '0 :
                 (inc & ~dec) ? cnt_q[r] + CNT_W'(1) :
                 (dec & ~inc & (cnt_q[r] != '0)) ? cnt_q[r] - CNT_W'(1) : cnt_q[r];
      if (!flush_i && dec && !inc && cnt_q[r] == '0) err_d = 1'b1;
    end
    stall_d = stall_q + 32'(issue_valid_i & ~issue_ready_o);
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      stall_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stall_q <= stall_d;
      err_q <= err_d;
    end
  assign stall_cnt_o = stall_q;
  assign err_underflow_o = err_q;
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard: vector table, directed corner sequences and random traffic against a reference model.
module tb_id_hazard_scoreboard;
  logic clk = 1'b0;
  logic reset, issue_valid, es_allowin, issue_ready;
  logic [4:0] s1a, s2a, issue_dest, wb_dest;
  logic s1u, s2u, issue_we, wb_valid, wb_we, flush, err_underflow;
  logic [31:0] s1rf, s2rf, wb_data, src1_value, src2_value, stall_cnt;
  logic [1:0] fv, fok;
  logic [4:0] fdst [2];
  logic [31:0] fdat [2];
  logic [9:0] fwd_dest;
  logic [63:0] fwd_data;
  int vectors = 0, miscompares = 0;
  int pend [32];
  logic [31:0] m_stall;
  bit m_err;
  assign fwd_dest = {fdst[1], fdst[0]};
  assign fwd_data = {fdat[1], fdat[0]};
  always #5 clk = ~clk;
  id_hazard_scoreboard dut (
    .clk_i(clk), .reset_i(reset), .issue_valid_i(issue_valid), .es_allowin_i(es_allowin),
    .issue_ready_o(issue_ready), .src1_addr_i(s1a), .src2_addr_i(s2a), .src1_used_i(s1u),
    .src2_used_i(s2u), .src1_rf_data_i(s1rf), .src2_rf_data_i(s2rf), .issue_we_i(issue_we),
    .issue_dest_i(issue_dest), .fwd_valid_i(fv), .fwd_data_ok_i(fok), .fwd_dest_i(fwd_dest),
    .fwd_data_i(fwd_data), .wb_valid_i(wb_valid), .wb_we_i(wb_we), .wb_dest_i(wb_dest),
    .wb_data_i(wb_data), .flush_i(flush), .src1_value_o(src1_value), .src2_value_o(src2_value),
    .stall_cnt_o(stall_cnt), .err_underflow_o(err_underflow)
  );
  typedef struct {
    logic [4:0] a1, a2; bit u1, u2; logic [1:0] v, ok; logic [4:0] d0, d1; logic [31:0] x0, x1;
    bit wbv; logic [4:0] wbd; logic [31:0] wbx; bit allow, rdy; logic [31:0] v1, v2;
  } vec_t;
  vec_t tbl [12];
  localparam logic [31:0] R1 = 32'h1111_1111, R2 = 32'h2222_2222;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic void res(input logic [4:0] a, input bit u, input logic [31:0] rf,
                              output bit hz, output logic [31:0] v);
    int found = -1;
    bit wbm;
    hz = 0;
    v = rf;
    if (a == 0) begin
      v = 0;
      return;
    end
    for (int i = 0; i < 2; i++) if (found < 0 && fv[i] && fdst[i] == a) found = i;
    if (found >= 0) begin
      v = fdat[found];
      hz = !fok[found];
    end else begin
      wbm = wb_valid && wb_we && wb_dest == a;
      v = wbm ? wb_data : rf;
      hz = pend[a] >= 2 || (pend[a] == 1 && !wbm);
    end
    if (!u) hz = 0;
  endfunction
  function automatic bit exp_ready();
    bit h1, h2, waw;
    logic [31:0] t;
    res(s1a, s1u, s1rf, h1, t);
    res(s2a, s2u, s2rf, h2, t);
    waw = issue_we && issue_dest != 0 && pend[issue_dest] == 3
          && !(wb_valid && wb_we && wb_dest == issue_dest);
    return es_allowin && !h1 && !h2 && !waw && !flush;
  endfunction
  function automatic void model_step();
    bit r = exp_ready();
    bit fire = issue_valid && r;
    bit inc = fire && issue_we && issue_dest != 0;
    bit ret = wb_valid && wb_we && wb_dest != 0;
    if (issue_valid && !r) m_stall++;
    if (flush) begin
      foreach (pend[k]) pend[k] = 0;
    end else if (!(inc && ret && wb_dest == issue_dest)) begin
      if (inc) pend[issue_dest]++;
      if (ret) begin
        if (pend[wb_dest] == 0) m_err = 1;
        else pend[wb_dest]--;
      end
    end
  endfunction
  function automatic void model_reset();
    foreach (pend[k]) pend[k] = 0;
    m_stall = 0;
    m_err = 0;
  endfunction
  task automatic cyc(input string nm);
    bit h;
    logic [31:0] v1, v2;
    #2;
    res(s1a, s1u, s1rf, h, v1);
    res(s2a, s2u, s2rf, h, v2);
    chk({nm, "_ready"}, {31'b0, issue_ready}, {31'b0, exp_ready()});
    chk({nm, "_v1"}, src1_value, v1);
    chk({nm, "_v2"}, src2_value, v2);
    @(posedge clk);
    model_step();
    #1;
    chk({nm, "_stall"}, stall_cnt, m_stall);
    chk({nm, "_err"}, {31'b0, err_underflow}, {31'b0, m_err});
  endtask
  task automatic idle();
    issue_valid = 0; es_allowin = 1; issue_we = 0; issue_dest = 0;
    s1a = 0; s2a = 0; s1u = 0; s2u = 0; s1rf = R1; s2rf = R2;
    fv = 0; fok = 0; fdst[0] = 0; fdst[1] = 0; fdat[0] = 0; fdat[1] = 0;
    wb_valid = 0; wb_we = 0; wb_dest = 0; wb_data = 0; flush = 0;
  endtask
  initial begin
    logic [31:0] s0;
    tbl[0]  = '{5'd3, 5'd4, 1, 1, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  0, 5'd0, 32'h0,  1, 1, R1, R2};
    tbl[1]  = '{5'd0, 5'd4, 1, 1, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  0, 5'd0, 32'h0,  1, 1, 32'h0, R2};
    tbl[2]  = '{5'd3, 5'd4, 1, 1, 2'b11, 2'b11, 5'd3, 5'd3, 32'h11, 32'h22, 0, 5'd0, 32'h0,  1, 1, 32'h11, R2};
    tbl[3]  = '{5'd3, 5'd4, 1, 1, 2'b11, 2'b10, 5'd3, 5'd3, 32'h11, 32'h22, 0, 5'd0, 32'h0,  1, 0, 32'h11, R2};
    tbl[4]  = '{5'd3, 5'd9, 1, 1, 2'b11, 2'b11, 5'd9, 5'd3, 32'h33, 32'h44, 0, 5'd0, 32'h0,  1, 1, 32'h44, 32'h33};
    tbl[5]  = '{5'd3, 5'd4, 1, 1, 2'b00, 2'b11, 5'd3, 5'd3, 32'h55, 32'h66, 0, 5'd0, 32'h0,  1, 1, R1, R2};
    tbl[6]  = '{5'd6, 5'd4, 1, 1, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  1, 5'd6, 32'h77, 1, 1, 32'h77, R2};
    tbl[7]  = '{5'd6, 5'd4, 1, 1, 2'b01, 2'b01, 5'd6, 5'd0, 32'h88, 32'h0,  1, 5'd6, 32'h77, 1, 1, 32'h88, R2};
    tbl[8]  = '{5'd3, 5'd4, 1, 1, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0,  32'h0,  0, 5'd0, 32'h0,  0, 0, R1, R2};
    tbl[9]  = '{5'd0, 5'd0, 1, 1, 2'b11, 2'b11, 5'd0, 5'd0, 32'h99, 32'h9a, 0, 5'd0, 32'h0,  1, 1, 32'h0, 32'h0};
    tbl[10] = '{5'd3, 5'd4, 0, 1, 2'b01, 2'b00, 5'd3, 5'd0, 32'hab, 32'h0,  0, 5'd0, 32'h0,  1, 1, 32'hab, R2};
    tbl[11] = '{5'd4, 5'd3, 1, 1, 2'b10, 2'b10, 5'd0, 5'd3, 32'h0,  32'hcd, 0, 5'd0, 32'h0,  1, 1, R1, 32'hcd};
    idle();
    reset = 1;
    model_reset();
    #1;
    chk("reset_stall", stall_cnt, 0);
    chk("reset_err", {31'b0, err_underflow}, 0);
    chk("reset_ready", {31'b0, issue_ready}, 1);
    @(negedge clk) reset = 0;
    for (int i = 0; i < 12; i++) begin
      s1a = tbl[i].a1; s2a = tbl[i].a2; s1u = tbl[i].u1; s2u = tbl[i].u2;
      fv = tbl[i].v; fok = tbl[i].ok; fdst[0] = tbl[i].d0; fdst[1] = tbl[i].d1;
      fdat[0] = tbl[i].x0; fdat[1] = tbl[i].x1;
      wb_valid = tbl[i].wbv; wb_we = tbl[i].wbv; wb_dest = tbl[i].wbd; wb_data = tbl[i].wbx;
      es_allowin = tbl[i].allow;
      #2;
      chk($sformatf("tbl%0d_ready", i), {31'b0, issue_ready}, {31'b0, tbl[i].rdy});
      chk($sformatf("tbl%0d_v1", i), src1_value, tbl[i].v1);
      chk($sformatf("tbl%0d_v2", i), src2_value, tbl[i].v2);
      @(posedge clk);
      model_step();
      #1;
    end
    chk("tbl_underflow", {31'b0, err_underflow}, 1);
    idle();
    reset = 1;
    model_reset();
    #1;
    chk("rst2_err", {31'b0, err_underflow}, 0);
    @(negedge clk) reset = 0;
    issue_valid = 1; issue_we = 1; issue_dest = 5;
    cyc("r036_add");
    chk("r036_add_fired", {31'b0, issue_ready}, 1);
    issue_we = 0; s1a = 5; s1u = 1;
    fv = 2'b01; fok = 2'b01; fdst[0] = 5; fdat[0] = 32'h1234;
    #2;
    chk("r036_ready", {31'b0, issue_ready}, 1);
    chk("r036_value", src1_value, 32'h1234);
    cyc("r036_use");
    chk("r036_nostall", stall_cnt, 0);
    fv = 2'b11; fok = 2'b10; fdst[0] = 5; fdst[1] = 5; fdat[0] = 32'hBB; fdat[1] = 32'hAA;
    s0 = m_stall;
    #2;
    chk("r037_ready", {31'b0, issue_ready}, 0);
    chk("r037_prio", src1_value, 32'hBB);
    cyc("r037_a");
    cyc("r037_b");
    chk("r037_stall", stall_cnt, s0 + 2);
    idle(); flush = 1;
    cyc("flush1");
    idle(); issue_valid = 1; issue_we = 1; issue_dest = 7;
    for (int k = 0; k < 3; k++) begin
      #2 chk($sformatf("r038_w%0d", k), {31'b0, issue_ready}, 1);
      cyc("r038_w");
    end
    #2 chk("r038_full", {31'b0, issue_ready}, 0);
    cyc("r038_full");
    wb_valid = 1; wb_we = 1; wb_dest = 7;
    #2 chk("r038_retire", {31'b0, issue_ready}, 1);
    cyc("r038_retire");
    wb_valid = 0; wb_we = 0;
    #2 chk("r038_still3", {31'b0, issue_ready}, 0);
    cyc("r038_still3");
    idle(); flush = 1;
    cyc("flush2");
    idle(); issue_valid = 1; issue_we = 1; issue_dest = 3;
    cyc("r039_i1");
    cyc("r039_i2");
    flush = 1; wb_valid = 1; wb_we = 1; wb_dest = 3;
    #2 chk("r039_flush_ready", {31'b0, issue_ready}, 0);
    cyc("r039_flush");
    idle(); issue_valid = 1; s1a = 3; s1u = 1; s1rf = 32'hC3C3;
    #2;
    chk("r039_ready", {31'b0, issue_ready}, 1);
    chk("r039_value", src1_value, 32'hC3C3);
    cyc("r039_read");
    idle(); wb_valid = 1; wb_we = 1; wb_dest = 9;
    cyc("r040_udf");
    chk("r040_err", {31'b0, err_underflow}, 1);
    idle();
    cyc("r040_hold");
    chk("r040_sticky", {31'b0, err_underflow}, 1);
    #2 reset = 1;
    model_reset();
    #1;
    chk("r040_rst_err", {31'b0, err_underflow}, 0);
    chk("r040_rst_stall", stall_cnt, 0);
    @(negedge clk) reset = 0;
    for (int n = 0; n < 3000; n++) begin
      issue_valid = $urandom_range(0, 3) != 0;
      es_allowin = $urandom_range(0, 7) != 0;
      issue_we = $urandom_range(0, 2) != 0;
      issue_dest = 5'($urandom_range(0, 7));
      s1a = 5'($urandom_range(0, 7)); s2a = 5'($urandom_range(0, 7));
      s1u = $urandom_range(0, 1); s2u = $urandom_range(0, 1);
      s1rf = $urandom; s2rf = $urandom;
      fv = 2'($urandom); fok = 2'($urandom_range(0, 3) | ($urandom_range(0, 1) ? 3 : 0));
      for (int i = 0; i < 2; i++) begin
        fdst[i] = 5'($urandom_range(0, 7));
        fdat[i] = $urandom;
      end
      wb_valid = $urandom_range(0, 1); wb_we = $urandom_range(0, 3) != 0;
      wb_dest = 5'($urandom_range(0, 7)); wb_data = $urandom;
      flush = $urandom_range(0, 15) == 0;
      cyc("rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
